// File: rtl/z80_bus_responder.sv
// z80_bus_responder
// Answers CPU-initiated Z80 bus cycles from the pin side of the bus.
// Memory and I/O cycles are forwarded to a single-beat backing store.
// nWAIT holds the CPU until the store acknowledges or a timeout expires.
// For interrupt acknowledge cycles, INT_VECTOR is placed on D.
//
// Ports
//   CPUCLK, nRESET        clock, asynchronous active-low reset
//   nM1 .. nRFSH, A       CPU strobes (active-low) and address
//   D                     bidirectional data bus (driven only when answering a read/INTA)
//   nWAIT, nINT           wait request and interrupt request to the CPU
//   irq / irq_ack         level interrupt request in, acknowledge-complete pulse out
//   mem_*                 backing-store request port
//   err                   one-cycle pulse when the store fails to acknowledge in time
module z80_bus_responder #(
    parameter logic [7:0] INT_VECTOR = 8'hFF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        CPUCLK,
    input  logic        nRESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    output logic        nWAIT,
    output logic        nINT,
    input  logic        irq,
    output logic        irq_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACCESS    = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;
    localparam logic [1:0] S_INTA_HOLD = 2'd3;

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        iack_q, iack_d;
    logic        err_q, err_d;
    logic        nint_q;

    // Strobe decode, highest priority first. INTA and refresh mask the rest.
    logic dec_inta, cyc_hit, cyc_we, cyc_io;
    logic strobes_idle;

    assign dec_inta     = ~nM1 & ~nIORQ;
    assign strobes_idle = nMREQ & nIORQ & nRD & nWR;

    always_comb begin
        cyc_hit = 1'b0;
        cyc_we  = 1'b0;
        cyc_io  = 1'b0;
        if (dec_inta) begin
            cyc_hit = 1'b0;
        end else if (~nMREQ & ~nRFSH) begin
            cyc_hit = 1'b0;
        end else if (~nMREQ & ~nRD) begin
            cyc_hit = 1'b1;
        end else if (~nMREQ & ~nWR) begin
            cyc_hit = 1'b1;
            cyc_we  = 1'b1;
        end else if (~nIORQ & ~nRD) begin
            cyc_hit = 1'b1;
            cyc_io  = 1'b1;
        end else if (~nIORQ & ~nWR) begin
            cyc_hit = 1'b1;
            cyc_we  = 1'b1;
            cyc_io  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        iack_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dec_inta) begin
                    state_d = S_INTA_HOLD;
                end else if (cyc_hit) begin
                    state_d = S_ACCESS;
                    req_d   = 1'b1;
                    we_d    = cyc_we;
                    io_d    = cyc_io;
                    addr_d  = A;
                    cnt_d   = TMO_LOAD;
                    if (cyc_we) wdata_d = D;
                end
            end
            S_ACCESS: begin
                // The cycle runs to completion even if the CPU drops its strobes.
                if (mem_ack) begin
                    state_d = S_HOLD;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = mem_rdata;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_HOLD;
                    req_d   = 1'b0;
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (strobes_idle) state_d = S_IDLE;
            end
            default: begin
                if (strobes_idle) begin
                    state_d = S_IDLE;
                    iack_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CPUCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            iack_q  <= 1'b0;
            err_q   <= 1'b0;
            nint_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            iack_q  <= iack_d;
            err_q   <= err_d;
            nint_q  <= ~irq;
        end
    end

    // Gating the decode term with nRESET keeps nWAIT released while reset is
    // held, even if the CPU still has its strobes asserted.
    assign nWAIT = ~((nRESET & (state_q == S_IDLE) & cyc_hit) | (state_q == S_ACCESS));

    logic       d_oe;
    logic [7:0] d_val;
    assign d_oe  = ((state_q == S_HOLD) & ~we_q & ~nRD) | ((state_q == S_INTA_HOLD) & ~nIORQ);
    assign d_val = (state_q == S_INTA_HOLD) ? INT_VECTOR : rdata_q;
    assign D     = d_oe ? d_val : 8'hzz;

    assign nINT      = nint_q;
    assign irq_ack   = iack_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_io    = io_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
